// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the UART command frontend of the 8-bit ALU tile:
// ALU control codes, opcode range and FSM state encodings.
package alu_cmd_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] CTRL_IDLE = 8'd0;
    localparam logic [DATA_W-1:0] CTRL_LD_A = 8'd1;
    localparam logic [DATA_W-1:0] CTRL_LD_B = 8'd2;
    localparam logic [DATA_W-1:0] CTRL_ADD  = 8'd4;
    localparam logic [DATA_W-1:0] CTRL_SUB  = 8'd5;
    localparam logic [DATA_W-1:0] CTRL_AND  = 8'd6;
    localparam logic [DATA_W-1:0] CTRL_OR   = 8'd7;

    // Opcode bytes accepted in the first position of a frame.
    localparam logic [DATA_W-1:0] OPC_MIN = CTRL_ADD;
    localparam logic [DATA_W-1:0] OPC_MAX = CTRL_OR;

    typedef enum logic [2:0] {
        F_OPC,
        F_A,
        F_B,
        F_ISS_A,
        F_ISS_B,
        F_ISS_OP
    } frame_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic opc_valid(input logic [DATA_W-1:0] b);
        return (b >= OPC_MIN) && (b <= OPC_MAX);
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling timer,
// RX FSM and LSB-first shift register. Emits one-cycle byte/error pulses.
module uart_rx_8n1
    import alu_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_byte,
    output logic              byte_valid,
    output logic              frame_err,
    output logic              rx_active
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic              rx_meta;
    logic              rx_s;
    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic              byte_valid_nxt;
    logic              frame_err_nxt;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Control state: FSM, bit timer, bit index and the result pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    // Received data bits; only meaningful alongside byte_valid.
    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

    // Next-state logic: the timer is re-zeroed at each sample point so
    // later samples stay centred on the bit cells.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + 1'b1;
        bit_idx_nxt    = bit_idx;
        shreg_nxt      = shreg;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[DATA_W-1:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt        = '0;
                    state_nxt      = RX_IDLE;
                    byte_valid_nxt = rx_s;
                    frame_err_nxt  = !rx_s;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign data_byte = shreg;
    assign rx_active = (state != RX_IDLE);

endmodule

// File: rtl/alu_cmd_uart_frontend.sv
// UART command frontend: parses (opcode, A, B) frames from the serial
// receiver and replays them as load-A, load-B, execute steps on the ALU bus.
module alu_cmd_uart_frontend
    import alu_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 16,
    parameter int FRAME_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err_frame,
    output logic              err_opcode,
    output logic              err_overrun
);

    localparam int TMO_W = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FRAME_TIMEOUT - 1);

    logic [DATA_W-1:0] rx_byte;
    logic              byte_valid;
    logic              frame_err;
    logic              rx_active;

    frame_state_t      state;
    frame_state_t      state_nxt;
    logic [DATA_W-1:0] op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              op_ld;
    logic              a_ld;
    logic              b_ld;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              in_operand;
    logic              tmo_hit;
    logic              issue_ack;
    logic              err_opcode_nxt;
    logic              err_overrun_nxt;
    logic              valid_nxt;
    logic [DATA_W-1:0] ctrl_nxt;
    logic [DATA_W-1:0] data_nxt;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx_i),
        .data_byte (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .rx_active (rx_active)
    );

    assign in_operand = (state == F_A) || (state == F_B);
    // Fires on the cycle the counter would reach FRAME_TIMEOUT.
    assign tmo_hit    = in_operand && !rx_active && (tmo_cnt == TMO_LAST);
    assign issue_ack  = out_valid && out_ready;

    // Idle timer for a partially received frame; any RX activity restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (byte_valid || rx_active || tmo_hit || !in_operand) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Operand latches; contents only matter once the frame is complete.
    always_ff @(posedge clk) begin
        if (op_ld) op_q <= rx_byte;
        if (a_ld)  a_q  <= rx_byte;
        if (b_ld)  b_q  <= rx_byte;
    end

    // Frame FSM next state; a received byte wins over error and timeout.
    always_comb begin
        state_nxt       = state;
        op_ld           = 1'b0;
        a_ld            = 1'b0;
        b_ld            = 1'b0;
        err_opcode_nxt  = 1'b0;
        err_overrun_nxt = 1'b0;
        case (state)
            F_OPC: begin
                if (byte_valid) begin
                    if (opc_valid(rx_byte)) begin
                        op_ld     = 1'b1;
                        state_nxt = F_A;
                    end else begin
                        err_opcode_nxt = 1'b1;
                    end
                end
            end
            F_A: begin
                if (byte_valid) begin
                    a_ld      = 1'b1;
                    state_nxt = F_B;
                end else if (frame_err || tmo_hit) begin
                    state_nxt = F_OPC;
                end
            end
            F_B: begin
                if (byte_valid) begin
                    b_ld      = 1'b1;
                    state_nxt = F_ISS_A;
                end else if (frame_err || tmo_hit) begin
                    state_nxt = F_OPC;
                end
            end
            F_ISS_A: begin
                err_overrun_nxt = byte_valid;
                if (issue_ack) state_nxt = F_ISS_B;
            end
            F_ISS_B: begin
                err_overrun_nxt = byte_valid;
                if (issue_ack) state_nxt = F_ISS_OP;
            end
            F_ISS_OP: begin
                err_overrun_nxt = byte_valid;
                if (issue_ack) state_nxt = F_OPC;
            end
            default: state_nxt = F_OPC;
        endcase
    end

    // Bus values for the state being entered, so a step is visible
    // together with its state and holds while the consumer stalls.
    always_comb begin
        valid_nxt = 1'b0;
        ctrl_nxt  = CTRL_IDLE;
        data_nxt  = '0;
        case (state_nxt)
            F_ISS_A: begin
                valid_nxt = 1'b1;
                ctrl_nxt  = CTRL_LD_A;
                data_nxt  = a_q;
            end
            F_ISS_B: begin
                valid_nxt = 1'b1;
                ctrl_nxt  = CTRL_LD_B;
                data_nxt  = b_q;
            end
            F_ISS_OP: begin
                valid_nxt = 1'b1;
                ctrl_nxt  = op_q;
            end
            default: ;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= F_OPC;
            out_valid   <= 1'b0;
            out_ctrl    <= '0;
            out_data    <= '0;
            busy        <= 1'b0;
            err_frame   <= 1'b0;
            err_opcode  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            out_valid   <= valid_nxt;
            out_ctrl    <= ctrl_nxt;
            out_data    <= data_nxt;
            busy        <= (state_nxt != F_OPC);
            err_frame   <= frame_err;
            err_opcode  <= err_opcode_nxt;
            err_overrun <= err_overrun_nxt;
        end
    end

endmodule
